// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared types and defaults for the HI/LO multiply/divide unit.
//   muldiv_op_t    : decoded muldiv-class operation from the E stage.
//   muldiv_state_t : sequencer state (IDLE / RUN / DONE).
//   DIV_STEPS_DEF  : iterations per long operation (one bit per cycle).
package muldiv_unit_pkg;

   localparam int XLEN          = 32;
   localparam int DIV_STEPS_DEF = 32;

   typedef enum logic [2:0] {
      MD_NONE,
      MD_MULT,
      MD_MULTU,
      MD_DIV,
      MD_DIVU,
      MD_MTHI,
      MD_MTLO
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_DONE
   } muldiv_state_t;

   function automatic logic isLongOp(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic isMulOp(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic isSignedOp(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter
//   Iterative datapath shared by restoring divide and shift-add multiply.
//   One 64-bit shift register {hiReg, loReg} plus an operand register.
//     divide  : loReg starts as the dividend and fills with quotient bits,
//               hiReg holds the partial remainder.
//     multiply: loReg starts as the multiplier and fills with low product
//               bits from the top, hiReg accumulates the upper product.
//   Ports:
//     clk, reset       clock, synchronous active-high reset
//     start            load operands (isMul selects the mode, latched)
//     step             perform one iteration this cycle
//     isMul            mode for the operation being started
//     dividend/divisor operand magnitudes (multiplicand/multiplier for mul)
//     q, r             result of the iteration being performed this cycle
//                      (low / high half); equals the final result on the
//                      last step, so the caller can commit at that edge.
module div_iter
   import muldiv_unit_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            step,
   input  logic            isMul,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] q,
   output logic [XLEN-1:0] r
);

   logic [XLEN-1:0] hiReg, loReg, opReg;
   logic            mulMode;

   logic [XLEN:0]   shifted;
   logic [XLEN:0]   sum;
   logic            ge;

   always_comb begin
      // restoring divide: shift in the next dividend bit, trial-subtract
      shifted = {hiReg, loReg[XLEN-1]};
      ge      = (shifted >= {1'b0, opReg});
      // shift-add multiply: conditional add, then shift right by one
      sum     = {1'b0, hiReg} + (loReg[0] ? {1'b0, opReg} : '0);
      if (mulMode) begin
         r = sum[XLEN:1];
         q = {sum[0], loReg[XLEN-1:1]};
      end else begin
         // when ge the difference is below the divisor, so 32 bits suffice
         r = ge ? (shifted[XLEN-1:0] - opReg) : shifted[XLEN-1:0];
         q = {loReg[XLEN-2:0], ge};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hiReg   <= '0;
         loReg   <= '0;
         opReg   <= '0;
         mulMode <= 1'b0;
      end else if (start) begin
         hiReg   <= '0;
         loReg   <= isMul ? divisor  : dividend;
         opReg   <= isMul ? dividend : divisor;
         mulMode <= isMul;
      end else if (step) begin
         hiReg   <= r;
         loReg   <= q;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO for the
//   execute stage. Sequences long ops (MULT/MULTU/DIV/DIVU) through an
//   iterative datapath, stalls F/D/E while they run, and commits HI/LO.
//   MTHI/MTLO write directly when E advances.
//   Optional build macro MYCPU_FAST_MULT_EN: multiplies use a single-cycle
//   32x32 product (IDLE -> DONE in one cycle); divide is unchanged.
//   Ports:
//     clk, reset  clock, synchronous active-high reset
//     valid, op   E-stage muldiv instruction and its decoded operation
//     a, b        rs / rt operand values, held while stall=1
//     adv         E advances to M at this edge
//     flush       kill the E-stage instruction
//     stall       freeze F/D/E (combinational)
//     hi, lo      architectural HI/LO registers
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int DIV_STEPS = DIV_STEPS_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid,
   input  muldiv_op_t      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            adv,
   input  logic            flush,
   output logic            stall,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CNT_W = $clog2(DIV_STEPS + 1);

   muldiv_state_t   state, stateNext;
   logic [CNT_W-1:0] cnt;
   muldiv_op_t      opReg;
   logic            signA, signB;

   logic            longOp, accept, start, commit, fastCommit, lastStep, mtWrite;
   logic            inSigned;
   logic [XLEN-1:0] magA, magB, q, r, quo, rem;
   logic [2*XLEN-1:0] prod, commitVal, fastProd;

   assign longOp   = isLongOp(op);
   assign inSigned = isSignedOp(op);
   assign accept   = (state == MD_IDLE) & valid & longOp & ~flush;
   assign lastStep = (state == MD_RUN) && (cnt == CNT_W'(DIV_STEPS - 1));
   assign mtWrite  = (state == MD_IDLE) & valid & adv & ~flush;
   assign magA     = (inSigned & a[XLEN-1]) ? -a : a;
   assign magB     = (inSigned & b[XLEN-1]) ? -b : b;

`ifdef MYCPU_FAST_MULT_EN
   logic [2*XLEN-1:0] aExt, bExt;
   assign aExt       = {{XLEN{inSigned & a[XLEN-1]}}, a};
   assign bExt       = {{XLEN{inSigned & b[XLEN-1]}}, b};
   // low 64 bits of the sign/zero-extended product are exact for both
   assign fastProd   = aExt * bExt;
   assign fastCommit = accept & isMulOp(op);
`else
   assign fastProd   = '0;
   assign fastCommit = 1'b0;
`endif

   assign start = accept & ~fastCommit;

   div_iter uIter (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .step     (state == MD_RUN),
      .isMul    (isMulOp(op)),
      .dividend (magA),
      .divisor  (magB),
      .q        (q),
      .r        (r)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= MD_IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      commit    = 1'b0;
      // DONE drops the stall so the same instruction can leave E
      stall     = valid & longOp & ~flush & ~reset & (state != MD_DONE);
      case (state)
         MD_IDLE: if (accept) stateNext = fastCommit ? MD_DONE : MD_RUN;
         MD_RUN: begin
            if (flush) begin
               stateNext = MD_IDLE;
            end else if (lastStep) begin
               commit    = 1'b1;
               stateNext = MD_DONE;
            end
         end
         // no restart while waiting: the finished instruction is still in E
         MD_DONE: if (flush | adv) stateNext = MD_IDLE;
         default: stateNext = MD_IDLE;
      endcase
   end

   // ---------------- sign fix-up at commit ----------------
   // signA/signB are latched as 0 for unsigned ops, so no op check needed
   always_comb begin
      prod      = {r, q};
      if (signA ^ signB) prod = -prod;
      quo       = (signA ^ signB) ? -q : q;
      rem       = signA ? -r : r;
      commitVal = isMulOp(opReg) ? prod : {rem, quo};
   end

   // ---------------- operand latch, counter ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         opReg <= MD_NONE;
         signA <= 1'b0;
         signB <= 1'b0;
      end else if (accept) begin
         cnt   <= '0;
         opReg <= op;
         signA <= inSigned & a[XLEN-1];
         signB <= inSigned & b[XLEN-1];
      end else if (state == MD_RUN) begin
         cnt   <= cnt + 1'b1;
      end
   end

   // ---------------- HI / LO ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         {hi, lo} <= commitVal;
      end else if (fastCommit) begin
         {hi, lo} <= fastProd;
      end else if (mtWrite) begin
         if (op == MD_MTHI) hi <= a;
         if (op == MD_MTLO) lo <= a;
      end
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS pipeline's execute stage. Decode produces MULT/MULTU/DIV/DIVU/MTHI/MTLO; this block sequences the iterative datapath, raises a stall while a long operation is in flight, and commits results to HI/LO. HI/LO are read by MFHI/MFLO in E.

## Interface
- `DIV_STEPS`, 32: iterations per divide (and per multiply when iterative).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  E-stage holds a muldiv-class instruction.
- `op`  in  `muldiv_op_t`  MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- `a`, `b`  in  32 each  rs / rt operand values (forwarded). Held stable while `stall`=1.
- `adv`  in  1  E stage advances to M at this edge.
- `flush`  in  1  kill E-stage instruction this cycle.
- `stall`  out  1  freeze F/D/E (combinational).
- `hi`, `lo`  out  32 each  registered HI/LO.

## Operation
- Long op = MULT/MULTU/DIV/DIVU. States: IDLE, RUN, DONE.
- IDLE: `valid` & long op & !`flush` → latch |a|, |b|, signs, op; `cnt`←0; → RUN. `stall`=1 in that cycle.
- RUN: one iteration per cycle; `cnt` increments. At `cnt`=DIV_STEPS-1, write HI/LO at the edge → DONE. `stall`=1 throughout RUN.
- DONE: `stall`=0. `adv` → IDLE. Otherwise hold DONE with no restart, even though the same instruction is still in E.
- `flush` in RUN or DONE → IDLE next edge. HI/LO untouched unless the write edge already occurred.
- Multiply: {HI,LO}=a×b, 64-bit. Signed for MULT, unsigned for MULTU.
- Divide: restoring, on magnitudes. LO=quotient, HI=remainder.
  - Quotient negative iff a[31]^b[31] (DIV only). Remainder takes the sign of a.
  - b=0: LO=32'hFFFFFFFF (unsigned magnitude result, then sign fix), HI=a.
  - 0x80000000 / -1 (DIV): LO=32'h80000000, HI=0.
- MTHI/MTLO: in IDLE, `valid` & `adv` & !`flush` → HI (or LO) ← `a` at the edge. No stall.
- `stall` = `valid` & long op & !`flush` & (state≠DONE).
- Simultaneous MTHI/MTLO and DONE-exit cannot occur: it is the same E slot.

## Timing
- Reset: state=IDLE, `cnt`=0, `hi`=0, `lo`=0, `stall`=0 (valid ignored during the reset cycle).
- Reset mid-RUN: IDLE next cycle, HI/LO cleared, no partial commit.
- Iterative long op accepted in cycle 0: `stall`=1 in cycles 0..DIV_STEPS. New HI/LO visible in cycle DIV_STEPS+1, with state=DONE and `stall`=0.
- A following MFHI/MFLO entering E sees the committed values with no bypass.
- Back-to-back long ops: DONE→IDLE on `adv`, next op accepted the following cycle.

## Configuration
- `MYCPU_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle 32×32 product. Accept cycle goes IDLE→DONE directly with HI/LO written at that edge.
  - `stall`=1 for exactly 1 cycle.
  - Divide unchanged.
- Undefined: multiply is iterative shift-add on magnitudes, DIV_STEPS cycles, same state flow and latency as divide. Sign fixed at commit (negate 64-bit product iff signs differ, MULT only).

## Structure
- Shared package / `mycpu/type.svh`: `muldiv_op_t`, `muldiv_state_t`, `DIV_STEPS` default.
- Sub-module `div_iter`: restoring-divide datapath.
  - Ports: `start`, `dividend`, `divisor` (magnitudes), remainder/quotient shift registers, one step per cycle, `q`/`r` out.
  - Iterative multiply shares the 64-bit shift register.
- Top holds the FSM, counter, sign fix-up, and HI/LO.

## Test plan
- DIVU a=100, b=7 → `stall` high 33 cycles, then LO=14, HI=2; `adv` next cycle → IDLE.
- DIV a=-7 (0xFFFFFFF9), b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT a=-3, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=1. Check `stall` length with and without `MYCPU_FAST_MULT_EN` (1 vs 33 cycles).
- DIV completes with `adv` held 0 for 5 cycles → stays DONE, `stall`=0, no recompute, HI/LO stable.
- `flush` at cycle 10 of RUN → IDLE, HI/LO keep prior values (MTHI 0x1234 earlier → HI=0x1234). Reset at cycle 20 of a second run → HI=LO=0, `stall`=0.
- MTLO a=0xDEAD with `adv`=1 → LO=0xDEAD next cycle. DIVU b=0, a=9 → LO=0xFFFFFFFF, HI=9.
